// File: rtl/id_hazard_ctrl.sv
// ID-stage issue controller: per-register in-flight write scoreboard with RAW/WAW stall and drain FSM.
// Optional build macro ID_STALL_STAT_EN adds a free-running stall cycle counter (stall_cnt_o).
module id_hazard_ctrl #(
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned REG_NUM = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid_i,
    input  logic [4:0] dec_rs1_idx_i,
    input  logic       dec_rs1_en_i,
    input  logic [4:0] dec_rs2_idx_i,
    input  logic       dec_rs2_en_i,
    input  logic [4:0] dec_rd_idx_i,
    input  logic       dec_rd_en_i,
    input  logic       flush_i,
    input  logic       wb_en_i,
    input  logic [4:0] wb_idx_i,
    input  logic       drain_req_i,
    output logic       id_stall_o,
    output logic       id_issue_o,
    output logic       drain_done_o,
    output logic       err_o
`ifdef ID_STALL_STAT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int unsigned IDX_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HALTED  = 2'd2
    } state_e;

    state_e           state_q;
    logic             drain_done_q;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] cnt_q [REG_NUM];
    logic [CNT_W-1:0] cnt_d [REG_NUM];

    logic raw1;
    logic raw2;
    logic waw_full;
    logic all_zero;
    logic stall;
    logic issue;

    // Hazard detection uses registered counts only; a same-cycle writeback does not unblock.
    always_comb begin
        raw1     = dec_rs1_en_i && (dec_rs1_idx_i != '0) && (cnt_q[dec_rs1_idx_i] != '0);
        raw2     = dec_rs2_en_i && (dec_rs2_idx_i != '0) && (cnt_q[dec_rs2_idx_i] != '0);
        waw_full = dec_rd_en_i  && (dec_rd_idx_i  != '0) && (cnt_q[dec_rd_idx_i]  == CNT_MAX);
        stall    = id_valid_i && !flush_i && (raw1 || raw2 || waw_full || (state_q != ST_RUN));
        issue    = id_valid_i && !flush_i && !stall;
    end

    assign id_stall_o   = stall;
    assign id_issue_o   = issue;
    assign drain_done_o = drain_done_q;
    assign err_o        = err_q;

    // Scoreboard next state: issue increments rd, writeback decrements wb_idx; x0 untouched.
    always_comb begin
        logic inc;
        logic dec;
        cnt_d    = cnt_q;
        err_d    = err_q;
        all_zero = 1'b1;
        inc      = 1'b0;
        dec      = 1'b0;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            inc = issue && dec_rd_en_i && (dec_rd_idx_i == IDX_W'(i));
            dec = wb_en_i && (wb_idx_i == IDX_W'(i)) && (cnt_q[i] != '0);
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            if (cnt_q[i] != '0) begin
                all_zero = 1'b0;
            end
        end
        if (wb_en_i && (wb_idx_i != '0) && (cnt_q[wb_idx_i] == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            err_q <= err_d;
        end
    end

    // Drain FSM; drain_done is registered alongside the state so it is high exactly in HALTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            drain_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (drain_req_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!drain_req_i) begin
                        state_q <= ST_RUN;
                    end else if (all_zero) begin
                        state_q      <= ST_HALTED;
                        drain_done_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!drain_req_i) begin
                        state_q      <= ST_RUN;
                        drain_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_RUN;
                    drain_done_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ID_STALL_STAT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
